// File: rtl/trojan_probe_sequencer.sv
// Built-in test sequencer: drives LFSR patterns into a registered subcircuit,
// compacts its response bit into a MISR and compares against a golden signature.
module trojan_probe_sequencer #(
   parameter int                NUM_IN  = 7,
   parameter int                PAT_CNT = 64,
   parameter int                LATENCY = 2,
   parameter int                SIG_W   = 16,
   parameter logic [NUM_IN-1:0] SEED    = NUM_IN'(1),
   parameter logic [SIG_W-1:0]  POLY    = SIG_W'(16'h1021)
) (
   input  logic              I2294,
   input  logic              I2301,
   input  logic              start,
   input  logic [SIG_W-1:0]  golden_sig,
   output logic [NUM_IN-1:0] dut_in,
   output logic              dut_rst_n,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [2:0]        o_dbg_state
);

   localparam int                CNT_W    = $clog2(PAT_CNT + LATENCY + 1);
   localparam logic [NUM_IN-1:0] SEED_EFF = (SEED == '0) ? NUM_IN'(1) : SEED;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FLUSH   = 3'd1,
      S_APPLY   = 3'd2,
      S_DRAIN   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             r_state;
   logic [NUM_IN-1:0]  r_lfsr;
   logic [CNT_W-1:0]   r_cnt;
   logic [LATENCY-1:0] r_vpipe;
   logic [SIG_W-1:0]   r_sig;
   logic [NUM_IN-1:0]  r_dut_in;
   logic               r_dut_rst_n;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;

   logic [NUM_IN-1:0]  w_lfsr_next;
   logic [SIG_W-1:0]   w_misr_next;
   logic               w_capture;

   // x^7+x^6+1 Fibonacci step, maximal length 127
   assign w_lfsr_next = {r_lfsr[NUM_IN-2:0], r_lfsr[NUM_IN-1] ^ r_lfsr[NUM_IN-2]};
   assign w_misr_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ {{(SIG_W-1){1'b0}}, dut_out};
   assign w_capture   = r_vpipe[LATENCY-1];

   always_ff @(posedge I2294) begin
      if (I2301) begin
         r_state     <= S_IDLE;
         r_lfsr      <= SEED_EFF;
         r_cnt       <= '0;
         r_vpipe     <= '0;
         r_sig       <= '0;
         r_dut_in    <= '0;
         r_dut_rst_n <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         // Tracks which response cycles belong to applied patterns
         r_vpipe[0] <= (r_state == S_APPLY);
         for (int i = 1; i < LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
         if (w_capture) begin
            r_sig <= w_misr_next;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               r_dut_rst_n <= 1'b1;
               if (start) begin
                  r_state     <= S_FLUSH;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_sig       <= '0;
                  r_lfsr      <= SEED_EFF;
                  r_dut_rst_n <= 1'b0;
                  r_dut_in    <= '0;
               end
            end
            S_FLUSH: begin
               r_state     <= S_APPLY;
               r_dut_rst_n <= 1'b1;
               r_dut_in    <= r_lfsr;
               r_lfsr      <= w_lfsr_next;
               r_cnt       <= '0;
            end
            S_APPLY: begin
               if (r_cnt == CNT_W'(PAT_CNT - 1)) begin
                  r_state  <= S_DRAIN;
                  r_dut_in <= '0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_dut_in <= r_lfsr;
                  r_lfsr   <= w_lfsr_next;
               end
            end
            S_DRAIN: begin
               if (r_cnt == CNT_W'(LATENCY - 1)) begin
                  r_state <= S_COMPARE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_COMPARE: begin
               r_pass  <= (r_sig == golden_sig);
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dut_in      = r_dut_in;
   assign dut_rst_n   = r_dut_rst_n;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign signature   = r_sig;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trojan_probe_sequencer.sv
// Bench for trojan_probe_sequencer: vector table, random runs against a
// pattern-level signature model, and hand-written multi-cycle sequences.
module tb_trojan_probe_sequencer;

   localparam int PAT_CNT  = 64;
   localparam int LATENCY  = 2;
   localparam int DONE_CYC = 3 + PAT_CNT + LATENCY;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] golden_sig = '0;
   logic [6:0]  dut_in;
   logic        dut_rst_n;
   logic        dut_out;
   logic        busy, done, pass;
   logic [15:0] signature;
   logic [2:0]  dbg_state;

   logic        start3 = 1'b0;
   logic [15:0] golden3 = '0;
   logic        one3 = 1'b1;
   logic [6:0]  dut_in3;
   logic        dut_rst_n3, busy3, done3, pass3;
   logic [15:0] sig3;
   logic [2:0]  dbg_state3;

   int          cfg_mode = 0;
   logic [6:0]  cfg_mask = '0;
   bit          cfg_inv = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trojan_probe_sequencer u_dut (
      .I2294(clk), .I2301(rst), .start(start), .golden_sig(golden_sig),
      .dut_in(dut_in), .dut_rst_n(dut_rst_n), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .signature(signature),
      .o_dbg_state(dbg_state)
   );

   trojan_probe_sequencer #(.PAT_CNT(3)) u_dut3 (
      .I2294(clk), .I2301(rst), .start(start3), .golden_sig(golden3),
      .dut_in(dut_in3), .dut_rst_n(dut_rst_n3), .dut_out(one3),
      .busy(busy3), .done(done3), .pass(pass3), .signature(sig3),
      .o_dbg_state(dbg_state3)
   );

   // Subcircuit under test: mode 0 tied 0, mode 1 tied 1, mode 2 parity
   // function, with an optional extra AND term modelling the Trojan gate.
   function automatic logic resp(input logic [6:0] p, input int mode,
                                 input logic [6:0] mask, input bit inv);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         default: return (^(p & mask)) ^ (inv & p[1] & p[4]);
      endcase
   endfunction

   function automatic logic [6:0] lfsr_step(input logic [6:0] q);
      return {q[5:0], q[6] ^ q[5]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
      logic [15:0] t;
      t = s << 1;
      if (s[15]) t = t ^ 16'h1021;
      return t ^ {15'b0, r};
   endfunction

   function automatic logic [15:0] model_sig(input int n, input int mode,
                                             input logic [6:0] mask, input bit inv);
      logic [6:0]  q;
      logic [15:0] s;
      q = 7'h01;
      s = '0;
      for (int k = 0; k < n; k++) begin
         s = misr_step(s, resp(q, mode, mask, inv));
         q = lfsr_step(q);
      end
      return s;
   endfunction

   logic sc1, sc2;
   always @(posedge clk) begin
      if (!dut_rst_n) begin
         sc1 <= 1'b0;
         sc2 <= 1'b0;
      end else begin
         sc1 <= resp(dut_in, cfg_mode, cfg_mask, cfg_inv);
         sc2 <= sc1;
      end
   end
   assign dut_out = sc2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      check("wait_done", done, 1);
   endtask

   logic [6:0] exp_first [7];

   task automatic run_vec(input int mode, input logic [6:0] mask, input bit inv,
                          input logic [15:0] gold, input logic [15:0] exp_sig,
                          input bit exp_pass, input bit timeline, input bit extra_starts);
      logic [6:0] q;
      int cyc;
      cfg_mode   = mode;
      cfg_mask   = mask;
      cfg_inv    = inv;
      golden_sig = gold;
      start = 1'b1;
      tick();
      cyc   = 1;
      start = 1'b0;
      check("flush_busy", busy, 1);
      check("flush_rst_n", dut_rst_n, 0);
      check("flush_dut_in", dut_in, 0);
      check("flush_done", done, 0);
      q = 7'h01;
      while (!done && cyc < DONE_CYC + 20) begin
         tick();
         cyc++;
         start = extra_starts && (cyc == 10 || cyc == 40);
         if (timeline) begin
            if (cyc >= 2 && cyc < 2 + PAT_CNT) begin
               check("apply_dut_in", dut_in, q);
               q = lfsr_step(q);
               if (cyc <= 8) check("first_patterns", dut_in, exp_first[cyc-2]);
            end else if (!done) begin
               check("drain_dut_in", dut_in, 0);
            end
            if (!done) check("busy_run", busy, 1);
         end
      end
      start = 1'b0;
      check("done_seen", done, 1);
      if (timeline || extra_starts) check("done_cycle", cyc, DONE_CYC);
      check("signature", signature, exp_sig);
      check("pass", pass, exp_pass);
      check("busy_done", busy, 0);
   endtask

   typedef struct {
      int          mode;
      logic [6:0]  mask;
      bit          inv;
      logic [15:0] golden;
      logic [15:0] exp_sig;
      bit          exp_pass;
   } vec_t;

   vec_t vecs [5];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];

   initial begin
      logic [15:0] clean_sig, troj_sig, s, prev;
      int n;

      exp_first = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
      clean_sig = model_sig(PAT_CNT, 2, 7'h5B, 1'b0);
      troj_sig  = model_sig(PAT_CNT, 2, 7'h5B, 1'b1);
      vecs[0] = '{0, 7'h00, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[1] = '{0, 7'h00, 1'b0, 16'h0001, 16'h0000, 1'b0};
      vecs[2] = '{1, 7'h00, 1'b0, model_sig(PAT_CNT, 1, 7'h00, 1'b0),
                  model_sig(PAT_CNT, 1, 7'h00, 1'b0), 1'b1};
      vecs[3] = '{2, 7'h5B, 1'b0, clean_sig, clean_sig, 1'b1};
      vecs[4] = '{2, 7'h5B, 1'b1, clean_sig, troj_sig, troj_sig == clean_sig};

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_sig", signature, 0);
      check("rst_dut_in", dut_in, 0);
      check("rst_dut_rst_n", dut_rst_n, 0);
      check("rst3_sig", sig3, 0);
      rst = 1'b0;
      repeat (2) tick();
      check("idle_dut_rst_n", dut_rst_n, 1);
      check("idle_busy", busy, 0);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i].mode, vecs[i].mask, vecs[i].inv, vecs[i].golden,
                 vecs[i].exp_sig, vecs[i].exp_pass, i == 0, i == 3);
         repeat (2) tick();
         check("done_level_held", done, 1);
      end

      // New start from DONE clears the result on the next cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_done", done, 0);
      check("restart_pass", pass, 0);
      check("restart_sig", signature, 0);
      check("restart_busy", busy, 1);
      wait_done(DONE_CYC + 10);

      // start held high across DONE relaunches the run
      start = 1'b1;
      tick();
      wait_done(DONE_CYC + 10);
      tick();
      check("held_start_busy", busy, 1);
      check("held_start_done", done, 0);
      start = 1'b0;
      wait_done(DONE_CYC + 10);

      // Reset asserted in cycle 30 of a run
      cfg_mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (29) tick();
      rst = 1'b1;
      tick();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass, 0);
      check("abort_sig", signature, 0);
      check("abort_dut_in", dut_in, 0);
      rst = 1'b0;
      tick();
      s = model_sig(PAT_CNT, 1, 7'h00, 1'b0);
      run_vec(1, 7'h00, 1'b0, s, s, 1'b1, 1'b1, 1'b0);

      // Three-pattern instance with response tied high: record every MISR step
      s = '0;
      for (int k = 0; k < 3; k++) begin
         s = misr_step(s, 1'b1);
         exp_q.push_back(s);
      end
      golden3 = 16'h0007;
      start3  = 1'b1;
      tick();
      start3 = 1'b0;
      prev = sig3;
      n = 1;
      while (!done3 && n < 40) begin
         tick();
         n++;
         if (sig3 !== prev) got_q.push_back(sig3);
         prev = sig3;
      end
      check("p3_done_cycle", n, 3 + 3 + LATENCY);
      check("p3_steps", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         check("p3_misr_step", got_q.pop_front(), exp_q.pop_front());
      end
      check("p3_sig", sig3, 16'h0007);
      check("p3_pass", pass3, 1);

      // Randomized runs against the pattern-level model
      for (int r = 0; r < 8; r++) begin
         int          m;
         logic [6:0]  mk;
         bit          iv;
         logic [15:0] g;
         m  = $urandom_range(0, 2);
         mk = 7'($urandom);
         iv = 1'($urandom_range(0, 1));
         s  = model_sig(PAT_CNT, m, mk, iv);
         g  = ($urandom_range(0, 1) == 1) ? s : 16'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         run_vec(m, mk, iv, g, s, g == s, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trojan_probe_sequencer.md
Name: trojan_probe_sequencer

Overview:
- Built-in test sequencer for the registered benchmark subcircuits: 7 primary inputs, one registered output, 2-cycle input-to-output latency.
- Drives a pseudo-random pattern stream into one subcircuit and captures its response bit into a multiple-input signature register (MISR).
- Compares the final signature against a golden value, so a Trojan-modified instance is flagged as a fail.

Parameters:
NUM_IN, 7, width of pattern driven to the subcircuit
PAT_CNT, 64, number of patterns applied per run (>=1)
LATENCY, 2, cycles from pattern applied to response valid at dut_out (>=1)
SIG_W, 16, MISR width
SEED, 7'h01, LFSR load value at run start; 0 is replaced by 1
POLY, 16'h1021, MISR feedback polynomial

Ports:
I2294  input  1  clock; all state updates on rising edge
I2301  input  1  reset; synchronous, active-high
start  input  1  run request; sampled only in IDLE or DONE
golden_sig  input  SIG_W  expected signature; sampled in COMPARE
dut_in  output  NUM_IN  pattern to subcircuit inputs
dut_rst_n  output  1  active-low reset to subcircuit flops
dut_out  input  1  subcircuit registered output
busy  output  1  high from FLUSH through COMPARE
done  output  1  run complete; level, held until next start or reset
pass  output  1  signature matched; valid while done=1
signature  output  SIG_W  current MISR contents

Behaviour:
- Reset values: state=IDLE, dut_in=0, dut_rst_n=0 while I2301=1 then 1, busy=0, done=0, pass=0, signature=0, LFSR=SEED, pattern counter=0, valid pipe=0.
- States: IDLE, FLUSH, APPLY, DRAIN, COMPARE, DONE.
- IDLE/DONE + start=1 -> FLUSH. Entering FLUSH clears done, pass and signature, and loads LFSR=SEED.
- FLUSH, 1 cycle: dut_rst_n=0, dut_in=0.
- FLUSH -> APPLY.
- APPLY, exactly PAT_CNT cycles:
  - dut_in=LFSR; LFSR advances each cycle as next={q[5:0], q[6]^q[5]} (x^7+x^6+1, period 127).
  - Counter counts 0..PAT_CNT-1.
  - The last cycle goes to DRAIN.
- Valid pipe: LATENCY-deep shift register, input=1 in APPLY, 0 otherwise.
- MISR update: when the pipe output=1, signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ {0, dut_out}. Exactly PAT_CNT updates per run.
- DRAIN, LATENCY cycles: dut_in=0; the remaining captures complete here.
- DRAIN -> COMPARE.
- COMPARE, 1 cycle: pass <= (signature==golden_sig).
- COMPARE -> DONE. In DONE: done=1, busy=0.
- Timeline for start sampled in cycle 0 (defaults): FLUSH 1, APPLY 2..65, DRAIN 66..67, COMPARE 68, done=1 from cycle 69.
- start while busy: ignored, no restart, no error.
- start held high in DONE: a new run begins each time DONE is reached.
- Reset mid-run: abort immediately to reset values; no partial done/pass.
- dut_out is ignored whenever the pipe output is 0.
- signature is readable at any time; it is frozen in COMPARE and DONE.

Test Plan:
- Reset, then start with SEED=1 -> cycle 1 dut_rst_n=0. Cycles 2..8 dut_in = 01,02,04,08,10,20,41. busy rises in cycle 1; done rises in cycle 69.
- dut_out tied 0, golden_sig=0 -> signature=16'h0000, done=1, pass=1. Repeat with golden_sig=16'h0001 -> pass=0.
- PAT_CNT=3, dut_out tied 1 -> MISR steps 0001, 0003, 0007. Final signature=16'h0007; golden 16'h0007 gives pass=1.
- Real subcircuit connected, golden taken from clean netlist -> pass=1. Same run with one gate inverted (Trojan model) -> pass=0.
- start pulsed again in cycles 10 and 40 -> ignored; done still rises at cycle 69 and exactly 64 MISR updates occur. Second start in DONE clears done/pass on the next cycle.
- I2301 asserted in cycle 30 of a run -> next cycle IDLE with busy=0, done=0, signature=0, dut_in=0. A fresh start then runs a full-length sequence.
